wr_burst_ctrl: RTL and testbench
================================

Name: wr_burst_ctrl

Overview:
Parametrised DDR write-burst engine for the video write path, entirely in the ddr_clk domain. It drains the read side of an upstream CDC FIFO (pixels already packed to DDR width) and issues fixed-length AXI-style write bursts. Each frame goes into one of N frame buffers in a ring, with a short tail burst at frame end. Per-frame completion and error status are reported to the frame-buffer read side.

Parameters:
DATA_W, 256, DDR beat width (8*MEM_DQ_WIDTH)
ADDR_W, 28, DDR address width
LEN_W, 8, burst length field width
MAX_BURST, 32, beats per full burst (1..2^LEN_W-1)
LVL_W, 10, FIFO read water-level width
BEAT_CNT_W, 20, frame beat counter width
ADDR_PER_BEAT, 8, address increment per beat (DATA_W/MEM_DQ_WIDTH)
BUF_IDX_W, 2, frame-buffer index width (up to 4 buffers)

Ports:
ddr_clk  in  1  clock
ddr_rstn  in  1  asynchronous active-low reset
frame_start  in  1  level frame sync, already synchronised to ddr_clk; rising edge starts a frame
cfg_base_addr  in  ADDR_W  address of buffer 0
cfg_buf_stride  in  ADDR_W  address distance between buffers
cfg_buf_num  in  BUF_IDX_W+1  buffers in ring, 1..2^BUF_IDX_W
cfg_frame_beats  in  BEAT_CNT_W  beats per frame, nonzero
fifo_rd_level  in  LVL_W  upstream FIFO read water level
fifo_rd_en  out  1  pop strobe; data on fifo_rd_data next cycle
fifo_rd_data  in  DATA_W  FIFO output
ddr_wreq  out  1  burst request
ddr_waddr  out  ADDR_W  burst start address
ddr_wr_len  out  LEN_W  burst length in beats
ddr_wdata_req  in  1  controller takes one beat this cycle
ddr_wdata  out  DATA_W  write beat
ddr_wdone  in  1  one-cycle pulse, burst complete
frame_done  out  1  one-cycle pulse, frame fully written
frame_buf_idx  out  BUF_IDX_W  buffer of last completed frame
frame_trunc  out  1  sticky, frame_start arrived before frame end; cleared by next clean frame_done

Behaviour:
- Reset (async, ddr_rstn=0): FSM IDLE. ddr_wreq, fifo_rd_en, frame_done, frame_trunc = 0. ddr_waddr, ddr_wr_len, frame_buf_idx, buffer index, beat counters = 0.
- Config (cfg_*) sampled on the frame_start rising edge only. Held constant during the frame.
- FSM:
  - IDLE: on frame_start rise, latch config, beats_left = cfg_frame_beats, go WAIT.
  - WAIT: len = min(MAX_BURST, beats_left). When fifo_rd_level >= len, go PREF.
  - PREF (1 cycle): fifo_rd_en=1 (prefetch beat 0); drive ddr_waddr/ddr_wr_len; go REQ.
  - REQ: ddr_wreq=1 (registered, set on PREF exit) until the first ddr_wdata_req; cleared in that cycle; go DATA.
  - DATA: ddr_wdata = fifo_rd_data, combinational from FIFO output. Each ddr_wdata_req counts one beat. fifo_rd_en = ddr_wdata_req AND beat_cnt != len-1, so exactly len pops per burst. After the len-th beat, go DONE.
  - DONE: wait ddr_wdone. Then beats_left -= len, burst address += len*ADDR_PER_BEAT. beats_left==0 -> FEND, else WAIT.
  - FEND (1 cycle): frame_done=1, frame_buf_idx=current idx. idx = (idx==cfg_buf_num-1) ? 0 : idx+1. Buffer base += stride, or reset to cfg_base_addr on wrap. No multiplier. Go IDLE.
- ddr_waddr = buffer base + beat offset*ADDR_PER_BEAT, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- frame_start rise in WAIT: abort immediately, set frame_trunc, restart frame in same buffer (no index advance). FIFO flush is the upstream's job via fsync reset.
- frame_start rise in PREF/REQ/DATA/DONE: latch pending. The burst in flight completes normally (never abort a DDR burst). At ddr_wdone, set frame_trunc and restart as in WAIT.
- Rise in FEND: handled in IDLE on the next cycle (edge latched).
- ddr_wdata_req beyond len beats: ignored, no pop. ddr_wdone outside DONE: ignored.
- cfg_frame_beats=0: treated as 1.

Decomposition:
- Shared package/header global.vh: DDR widths, MAX_BURST, ADDR_PER_BEAT, FSM state encoding localparams.
- One natural sub-module: wr_buf_ring (buffer index/base-address ring advance, with wrap).

Test Plan:
- frame_beats=64, MAX_BURST=32, base=0x100, level held 40 -> two bursts at 0x100/len32 and 0x200/len32, 64 pops total, frame_done once, frame_buf_idx=0.
- frame_beats=70 -> bursts len 32,32,6 at offsets 0, 256, 512. Tail ddr_wr_len=6, 6 pops.
- buf_num=3, stride=0x10000, four frames -> frame bases 0x100, 0x10100, 0x20100, 0x100; frame_buf_idx 0,1,2,0.
- Level 31 for 100 cycles, then 32 -> no ddr_wreq until level reaches 32; PREF pop precedes ddr_wreq by 1 cycle.
- frame_start during DATA of burst 2 -> burst 2 completes all 32 beats, frame_trunc=1, next burst address = same buffer base, no frame_done for the aborted frame.
- ddr_rstn low mid-DATA -> all outputs 0 asynchronously; after release the first frame_start writes buffer 0.

Source files
------------

// File: rtl/wr_burst_ctrl_pkg.sv
// Shared widths, burst constants and FSM encoding for the DDR write-burst engine.
package wr_burst_ctrl_pkg;

  localparam int DEF_DATA_W        = 256;
  localparam int DEF_ADDR_W        = 28;
  localparam int DEF_LEN_W         = 8;
  localparam int DEF_MAX_BURST     = 32;
  localparam int DEF_LVL_W         = 10;
  localparam int DEF_BEAT_CNT_W    = 20;
  localparam int DEF_ADDR_PER_BEAT = 8;
  localparam int DEF_BUF_IDX_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // waiting for a frame_start rise
    S_WAIT = 3'd1,  // waiting for enough FIFO data for the next burst
    S_PREF = 3'd2,  // prefetch beat 0, present address/length
    S_REQ  = 3'd3,  // burst request raised, waiting for first beat
    S_DATA = 3'd4,  // streaming the remaining beats
    S_DONE = 3'd5,  // waiting for the controller's completion pulse
    S_FEND = 3'd6   // frame complete, advance the buffer ring
  } state_t;

endpackage

// File: rtl/wr_burst_ctrl_ring.sv
// Frame-buffer ring: tracks the current buffer index and its base address.
// The base is advanced by accumulating the stride, so no multiplier is needed.
module wr_buf_ring
  import wr_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BUF_IDX_W = DEF_BUF_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [ADDR_W-1:0]    cfg_buf_stride,
  input  logic [BUF_IDX_W:0]   cfg_buf_num,
  output logic [BUF_IDX_W-1:0] idx,
  output logic [ADDR_W-1:0]    base
);

  logic [ADDR_W-1:0] base_lat;
  logic [ADDR_W-1:0] stride_lat;
  logic [BUF_IDX_W:0] num_lat;
  logic [BUF_IDX_W:0] idx_inc;
  logic               wrap;

  // A zero buffer count wraps on every frame, i.e. behaves as a single buffer.
  assign idx_inc = {1'b0, idx} + (BUF_IDX_W+1)'(1);
  assign wrap    = (idx_inc >= num_lat);

  // Latch frame config at frame start; step index/base when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      base       <= '0;
      base_lat   <= '0;
      stride_lat <= '0;
      num_lat    <= '0;
    end else if (load) begin
      base_lat   <= cfg_base_addr;
      stride_lat <= cfg_buf_stride;
      num_lat    <= cfg_buf_num;
      // Buffer 0 always sits at the configured base; later buffers keep the
      // accumulated base so a restarted frame stays in the same buffer.
      if (idx == '0) base <= cfg_base_addr;
    end else if (advance) begin
      if (wrap) begin
        idx  <= '0;
        base <= base_lat;
      end else begin
        idx  <= idx_inc[BUF_IDX_W-1:0];
        base <= base + stride_lat;
      end
    end
  end

endmodule

// File: rtl/wr_burst_ctrl.sv
// DDR write-burst engine: drains the CDC FIFO read side into fixed-length
// write bursts, one frame per ring buffer, with a short tail burst at frame end.
module wr_burst_ctrl
  import wr_burst_ctrl_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int LEN_W         = DEF_LEN_W,
  parameter int MAX_BURST     = DEF_MAX_BURST,
  parameter int LVL_W         = DEF_LVL_W,
  parameter int BEAT_CNT_W    = DEF_BEAT_CNT_W,
  parameter int ADDR_PER_BEAT = DEF_ADDR_PER_BEAT,
  parameter int BUF_IDX_W     = DEF_BUF_IDX_W
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rstn,
  input  logic                  frame_start,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [ADDR_W-1:0]     cfg_buf_stride,
  input  logic [BUF_IDX_W:0]    cfg_buf_num,
  input  logic [BEAT_CNT_W-1:0] cfg_frame_beats,
  input  logic [LVL_W-1:0]      fifo_rd_level,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic                  ddr_wreq,
  output logic [ADDR_W-1:0]     ddr_waddr,
  output logic [LEN_W-1:0]      ddr_wr_len,
  input  logic                  ddr_wdata_req,
  output logic [DATA_W-1:0]     ddr_wdata,
  input  logic                  ddr_wdone,
  output logic                  frame_done,
  output logic [BUF_IDX_W-1:0]  frame_buf_idx,
  output logic                  frame_trunc
);

  state_t state, state_nx;

  logic                  fs_d;
  logic                  fs_rise;
  logic                  pend;
  logic [BEAT_CNT_W-1:0] beats_left;
  logic [BEAT_CNT_W-1:0] beats_rem;
  logic [BEAT_CNT_W-1:0] len_w;
  logic [LEN_W-1:0]      beat_cnt;
  logic [ADDR_W-1:0]     addr_off;
  logic [ADDR_W-1:0]     ring_base;
  logic [BUF_IDX_W-1:0]  ring_idx;
  logic                  level_ok;
  logic                  last_beat;
  logic                  frame_load;
  logic                  ring_adv;
  logic                  beat_take;

  assign fs_rise   = frame_start & ~fs_d;
  assign len_w     = (beats_left > BEAT_CNT_W'(MAX_BURST)) ? BEAT_CNT_W'(MAX_BURST) : beats_left;
  assign level_ok  = (32'(fifo_rd_level) >= 32'(len_w));
  assign last_beat = (beat_cnt == ddr_wr_len - LEN_W'(1));
  assign beats_rem = beats_left - BEAT_CNT_W'(ddr_wr_len);

  assign ddr_wdata  = fifo_rd_data;
  assign frame_done = (state == S_FEND);

  wr_buf_ring #(
    .ADDR_W   (ADDR_W),
    .BUF_IDX_W(BUF_IDX_W)
  ) u_ring (
    .clk           (ddr_clk),
    .rst_n         (ddr_rstn),
    .load          (frame_load),
    .advance       (ring_adv),
    .cfg_base_addr (cfg_base_addr),
    .cfg_buf_stride(cfg_buf_stride),
    .cfg_buf_num   (cfg_buf_num),
    .idx           (ring_idx),
    .base          (ring_base)
  );

  // State register.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held over from a previous evaluation (no latch inferred).
    state_nx   = state;
    fifo_rd_en = 1'b0;
    frame_load = 1'b0;
    ring_adv   = 1'b0;
    beat_take  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fs_rise || pend) begin
          frame_load = 1'b1;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Nothing is in flight yet, so a new frame can abort at once.
        if (fs_rise)       frame_load = 1'b1;
        else if (level_ok) state_nx   = S_PREF;
      end
      S_PREF: begin
        fifo_rd_en = 1'b1;
        state_nx   = S_REQ;
      end
      S_REQ, S_DATA: begin
        // Beat 0 is already on fifo_rd_data; pop only while beats remain.
        if (ddr_wdata_req) begin
          beat_take  = 1'b1;
          fifo_rd_en = ~last_beat;
          state_nx   = last_beat ? S_DONE : S_DATA;
        end
      end
      S_DONE: begin
        if (ddr_wdone) begin
          if (pend || fs_rise) begin
            frame_load = 1'b1;
            state_nx   = S_WAIT;
          end else if (beats_rem == '0) begin
            state_nx = S_FEND;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_FEND: begin
        ring_adv = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame/burst bookkeeping, request handshake and status registers.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      fs_d          <= 1'b0;
      pend          <= 1'b0;
      beats_left    <= '0;
      addr_off      <= '0;
      beat_cnt      <= '0;
      ddr_wreq      <= 1'b0;
      ddr_waddr     <= '0;
      ddr_wr_len    <= '0;
      frame_buf_idx <= '0;
      frame_trunc   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register in this block
      // sees the pre-edge value of the others regardless of statement order.
      fs_d <= frame_start;

      // A rise while a burst is in flight (or during FEND) is remembered and
      // acted on once the burst or frame closes.
      if (frame_load)                                   pend <= 1'b0;
      else if (fs_rise && state != S_IDLE && state != S_WAIT) pend <= 1'b1;

      if (frame_load) begin
        beats_left <= (cfg_frame_beats == '0) ? BEAT_CNT_W'(1) : cfg_frame_beats;
        addr_off   <= '0;
        if (state != S_IDLE) frame_trunc <= 1'b1;
      end else if (state == S_DONE && ddr_wdone) begin
        beats_left <= beats_rem;
        addr_off   <= addr_off + ADDR_W'(ddr_wr_len) * ADDR_W'(ADDR_PER_BEAT);
        if (beats_rem == '0) frame_buf_idx <= ring_idx;
      end

      if (state == S_FEND) frame_trunc <= 1'b0;

      if (state == S_WAIT && state_nx == S_PREF) begin
        ddr_wr_len <= LEN_W'(len_w);
        ddr_waddr  <= ring_base + addr_off;
      end

      if (state == S_PREF)                      ddr_wreq <= 1'b1;
      else if (state == S_REQ && ddr_wdata_req) ddr_wreq <= 1'b0;

      if (beat_take) beat_cnt <= last_beat ? '0 : beat_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Directed bench for wr_burst_ctrl with a FIFO model and a DDR controller responder.
module tb_wr_burst_ctrl;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 28;
  localparam int LEN_W  = 8;

  logic              ddr_clk = 1'b0;
  logic              ddr_rstn = 1'b1;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = 28'h100;
  logic [ADDR_W-1:0] cfg_buf_stride = 28'h10000;
  logic [2:0]        cfg_buf_num = 3'd1;
  logic [19:0]       cfg_frame_beats = 20'd64;
  logic [9:0]        fifo_rd_level = 10'd40;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              ddr_wreq;
  logic [ADDR_W-1:0] ddr_waddr;
  logic [LEN_W-1:0]  ddr_wr_len;
  logic              ddr_wdata_req = 1'b0;
  logic [DATA_W-1:0] ddr_wdata;
  logic              ddr_wdone = 1'b0;
  logic              frame_done;
  logic [1:0]        frame_buf_idx;
  logic              frame_trunc;

  int n_checks = 0;
  int n_fail   = 0;

  // Logs filled by the responder and monitors.
  logic [ADDR_W-1:0] q_addr[$];
  logic [LEN_W-1:0]  q_len[$];
  logic [1:0]        done_idx[$];
  int pop_cnt  = 0;
  int beat_seq = 0;
  int done_cnt = 0;
  int data_err = 0;
  bit extra_req = 0;

  always #5 ddr_clk = ~ddr_clk;

  wr_burst_ctrl dut (
    .ddr_clk        (ddr_clk),
    .ddr_rstn       (ddr_rstn),
    .frame_start    (frame_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_buf_stride (cfg_buf_stride),
    .cfg_buf_num    (cfg_buf_num),
    .cfg_frame_beats(cfg_frame_beats),
    .fifo_rd_level  (fifo_rd_level),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .ddr_wreq       (ddr_wreq),
    .ddr_waddr      (ddr_waddr),
    .ddr_wr_len     (ddr_wr_len),
    .ddr_wdata_req  (ddr_wdata_req),
    .ddr_wdata      (ddr_wdata),
    .ddr_wdone      (ddr_wdone),
    .frame_done     (frame_done),
    .frame_buf_idx  (frame_buf_idx),
    .frame_trunc    (frame_trunc)
  );

  // FIFO read side: pop k presents pattern k on the next cycle.
  always @(posedge ddr_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= {8{pop_cnt}};
      pop_cnt++;
    end
  end

  // Frame completion monitor.
  always @(negedge ddr_clk) begin
    if (ddr_rstn && frame_done) begin
      done_cnt++;
      done_idx.push_back(frame_buf_idx);
    end
  end

  // DDR controller: take len beats after a request, then pulse wdone.
  initial begin : responder
    int n;
    forever begin
      @(negedge ddr_clk);
      if (ddr_rstn && ddr_wreq) begin
        q_addr.push_back(ddr_waddr);
        q_len.push_back(ddr_wr_len);
        n = int'(ddr_wr_len);
        for (int b = 0; b < n && ddr_rstn; b++) begin
          ddr_wdata_req = 1'b1;
          if (ddr_wdata !== {8{beat_seq}}) data_err++;
          beat_seq++;
          @(negedge ddr_clk);
        end
        ddr_wdata_req = 1'b0;
        if (extra_req && ddr_rstn) begin
          ddr_wdata_req = 1'b1;
          @(negedge ddr_clk);
          ddr_wdata_req = 1'b0;
        end
        @(negedge ddr_clk);
        if (ddr_rstn) begin
          ddr_wdone = 1'b1;
          @(negedge ddr_clk);
          ddr_wdone = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    q_addr.delete();
    q_len.delete();
    done_idx.delete();
    pop_cnt  = 0;
    beat_seq = 0;
    done_cnt = 0;
    data_err = 0;
  endtask

  task automatic do_reset();
    @(negedge ddr_clk);
    ddr_rstn = 1'b0;
    repeat (3) @(negedge ddr_clk);
    ddr_rstn = 1'b1;
    @(negedge ddr_clk);
    clear_log();
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    repeat (2) @(negedge ddr_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int c = 0; c < budget && done_cnt < n; c++) @(negedge ddr_clk);
    repeat (2) @(negedge ddr_clk);
  endtask

  task automatic wait_bursts(input int n, input int budget);
    for (int c = 0; c < budget && q_addr.size() < n; c++) @(negedge ddr_clk);
  endtask

  function automatic bit bursts_match(input logic [ADDR_W-1:0] ea[$], input logic [LEN_W-1:0] el[$]);
    bit ok = (q_addr.size() == ea.size()) && (q_len.size() == el.size());
    foreach (ea[i]) if (ok && (q_addr[i] !== ea[i] || q_len[i] !== el[i])) ok = 0;
    return ok;
  endfunction

  task automatic test_reset();
    ddr_rstn = 1'b0;
    #1;
    n_checks++;
    if ({ddr_wreq, fifo_rd_en, frame_done, frame_trunc} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000", {ddr_wreq, fifo_rd_en, frame_done, frame_trunc});
    end
    n_checks++;
    if (ddr_waddr !== '0 || ddr_wr_len !== '0 || frame_buf_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr %h len %0d idx %0d required 0/0/0", ddr_waddr, ddr_wr_len, frame_buf_idx);
    end
    repeat (3) @(negedge ddr_clk);
    ddr_rstn = 1'b1;
    @(negedge ddr_clk);
    clear_log();
  endtask

  task automatic test_two_bursts();
    logic [ADDR_W-1:0] ea[$];
    logic [LEN_W-1:0]  el[$];
    ea = '{28'h100, 28'h200};
    el = '{8'd32, 8'd32};
    cfg_buf_num = 3'd1; cfg_frame_beats = 20'd64; fifo_rd_level = 10'd40;
    pulse_frame_start();
    wait_frames(1, 2000);
    n_checks++;
    if (!bursts_match(ea, el)) begin
      n_fail++;
      $display("FAIL two_bursts: got addr %p len %p required addr %p len %p", q_addr, q_len, ea, el);
    end
    n_checks++;
    if (pop_cnt != 64 || data_err != 0) begin
      n_fail++;
      $display("FAIL two_bursts_pops: got %0d pops %0d data errors required 64 pops 0 errors", pop_cnt, data_err);
    end
    n_checks++;
    if (done_cnt != 1 || done_idx.size() != 1 || done_idx[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL two_bursts_done: got %0d done idx %p required 1 done idx 0", done_cnt, done_idx);
    end
    clear_log();
  endtask

  task automatic test_tail();
    logic [ADDR_W-1:0] ea[$];
    logic [LEN_W-1:0]  el[$];
    ea = '{28'h100, 28'h200, 28'h300};
    el = '{8'd32, 8'd32, 8'd6};
    cfg_frame_beats = 20'd70;
    extra_req = 1;  // one surplus data request after each burst
    pulse_frame_start();
    wait_frames(1, 3000);
    extra_req = 0;
    n_checks++;
    if (!bursts_match(ea, el)) begin
      n_fail++;
      $display("FAIL tail_bursts: got addr %p len %p required addr %p len %p", q_addr, q_len, ea, el);
    end
    n_checks++;
    if (pop_cnt != 70 || data_err != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL tail_pops: got %0d pops %0d errors %0d done required 70/0/1", pop_cnt, data_err, done_cnt);
    end
    clear_log();
  endtask

  task automatic test_zero_beats();
    logic [ADDR_W-1:0] ea[$];
    logic [LEN_W-1:0]  el[$];
    ea = '{28'h100};
    el = '{8'd1};
    cfg_frame_beats = 20'd0;
    pulse_frame_start();
    wait_frames(1, 500);
    n_checks++;
    if (!bursts_match(ea, el) || pop_cnt != 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_beats: got addr %p len %p pops %0d done %0d required addr 100 len 1 pops 1 done 1", q_addr, q_len, pop_cnt, done_cnt);
    end
    clear_log();
  endtask

  task automatic test_ring();
    logic [ADDR_W-1:0] ea[$];
    logic [LEN_W-1:0]  el[$];
    logic [1:0]        ei[$];
    bit ok;
    ea = '{28'h100, 28'h10100, 28'h20100, 28'h100};
    el = '{8'd8, 8'd8, 8'd8, 8'd8};
    ei = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    cfg_buf_num = 3'd3; cfg_frame_beats = 20'd8;
    for (int f = 0; f < 4; f++) begin
      pulse_frame_start();
      wait_frames(f + 1, 500);
    end
    n_checks++;
    if (!bursts_match(ea, el)) begin
      n_fail++;
      $display("FAIL ring_bases: got addr %p len %p required addr %p len %p", q_addr, q_len, ea, el);
    end
    ok = (done_idx.size() == 4);
    foreach (ei[i]) if (ok && done_idx[i] !== ei[i]) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ring_idx: got %p required %p", done_idx, ei);
    end
    clear_log();
  endtask

  task automatic test_level();
    bit saw, found, wreq_at_pop;
    logic [LEN_W-1:0] len_at_pop;
    do_reset();
    cfg_buf_num = 3'd1; cfg_frame_beats = 20'd32; fifo_rd_level = 10'd31;
    pulse_frame_start();
    saw = 0;
    repeat (100) begin
      @(negedge ddr_clk);
      if (ddr_wreq || fifo_rd_en) saw = 1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL level_hold: got request/pop at level 31 required none");
    end
    fifo_rd_level = 10'd32;
    found = 0; wreq_at_pop = 0; len_at_pop = '0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge ddr_clk);
      if (fifo_rd_en) begin
        found = 1;
        wreq_at_pop = ddr_wreq;
        len_at_pop  = ddr_wr_len;
      end
    end
    n_checks++;
    if (!found || wreq_at_pop !== 1'b0 || len_at_pop !== 8'd32) begin
      n_fail++;
      $display("FAIL level_pref: got pop %0d wreq %0d len %0d required pop 1 wreq 0 len 32", found, wreq_at_pop, len_at_pop);
    end
    @(negedge ddr_clk);
    n_checks++;
    if (ddr_wreq !== 1'b1) begin
      n_fail++;
      $display("FAIL level_req: got ddr_wreq %b one cycle after prefetch required 1", ddr_wreq);
    end
    wait_frames(1, 500);
    fifo_rd_level = 10'd40;
    n_checks++;
    if (done_cnt != 1 || pop_cnt != 32) begin
      n_fail++;
      $display("FAIL level_done: got %0d done %0d pops required 1/32", done_cnt, pop_cnt);
    end
    clear_log();
  endtask

  task automatic test_abort();
    logic [ADDR_W-1:0] ea[$];
    logic [LEN_W-1:0]  el[$];
    ea = '{28'h100, 28'h200, 28'h100};
    el = '{8'd32, 8'd32, 8'd32};
    do_reset();
    cfg_buf_num = 3'd2; cfg_frame_beats = 20'd96;
    pulse_frame_start();
    wait_bursts(2, 500);
    repeat (5) @(negedge ddr_clk);
    cfg_frame_beats = 20'd32;
    pulse_frame_start();
    wait_bursts(3, 500);
    n_checks++;
    if (q_addr.size() != 3 || frame_trunc !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_trunc: got %0d bursts trunc %b done %0d required 3 bursts trunc 1 done 0", q_addr.size(), frame_trunc, done_cnt);
    end
    wait_frames(1, 500);
    n_checks++;
    if (!bursts_match(ea, el) || pop_cnt != 96 || data_err != 0) begin
      n_fail++;
      $display("FAIL abort_bursts: got addr %p len %p pops %0d errors %0d required addr %p len %p pops 96", q_addr, q_len, pop_cnt, data_err, ea, el);
    end
    n_checks++;
    if (done_cnt != 1 || done_idx.size() != 1 || done_idx[0] !== 2'd0 || frame_trunc !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d done idx %p trunc %b required 1 done idx 0 trunc 0", done_cnt, done_idx, frame_trunc);
    end
    clear_log();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_buf_num = 3'd3; cfg_frame_beats = 20'd32;
    pulse_frame_start();
    wait_frames(1, 500);
    pulse_frame_start();
    wait_frames(2, 500);
    pulse_frame_start();
    wait_bursts(3, 500);
    repeat (5) @(negedge ddr_clk);
    n_checks++;
    if (ddr_waddr !== 28'h20100 || frame_buf_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got addr %h idx %0d required 20100 idx 1", ddr_waddr, frame_buf_idx);
    end
    #2 ddr_rstn = 1'b0;
    #1;
    n_checks++;
    if ({ddr_wreq, fifo_rd_en, frame_done, frame_trunc} !== 4'b0 || ddr_waddr !== '0 ||
        ddr_wr_len !== '0 || frame_buf_idx !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got strobes %b addr %h len %0d idx %0d required all 0",
               {ddr_wreq, fifo_rd_en, frame_done, frame_trunc}, ddr_waddr, ddr_wr_len, frame_buf_idx);
    end
    repeat (3) @(negedge ddr_clk);
    ddr_rstn = 1'b1;
    @(negedge ddr_clk);
    clear_log();
    pulse_frame_start();
    wait_frames(1, 500);
    n_checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 28'h100 || done_cnt != 1 || done_idx[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_after: got addr %p done %0d idx %p required addr 100 done 1 idx 0", q_addr, done_cnt, done_idx);
    end
    clear_log();
  endtask

  initial begin : main
    test_reset();
    test_two_bursts();
    test_tail();
    test_zero_beats();
    test_ring();
    test_level();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
